// File: rtl/vga_timing_gen_if.sv
// Pixel timing bundle between vga_timing_gen and the RGB stage / frame memory.
// Pattern exists only when VGA_TIMING_TEST_PATTERN_EN is defined.
interface vga_timing_gen_if;
  logic       Ce;
  logic [9:0] X;
  logic [9:0] Y;
  logic       Hsync;
  logic       Vsync;
  logic       Nblank;
  logic       Frame_start;
`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic [11:0] Pattern;
`endif

  modport master (
    input  Ce,
    output X, Y, Hsync, Vsync, Nblank, Frame_start
`ifdef VGA_TIMING_TEST_PATTERN_EN
    , output Pattern
`endif
  );

  modport slave (
    output Ce,
    input  X, Y, Hsync, Vsync, Nblank, Frame_start
`ifdef VGA_TIMING_TEST_PATTERN_EN
    , input Pattern
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA pixel timing generator: X/Y counters plus sync/blank delayed by RD_LAT pixel ticks.
// Optional 8-bar test pattern output when VGA_TIMING_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic               Clk,
  input  logic               Rst,
  vga_timing_gen_if.master   vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024) begin : g_h_total_check
    $error("vga_timing_gen: H_TOTAL exceeds the 10-bit X counter");
  end
  if (V_TOTAL > 1024) begin : g_v_total_check
    $error("vga_timing_gen: V_TOTAL exceeds the 10-bit Y counter");
  end
  if (RD_LAT > 7) begin : g_rd_lat_check
    $error("vga_timing_gen: RD_LAT must be 0..7");
  end

  localparam logic [9:0]  X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        nb;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [11:0] pat;
`endif
  } tap_t;

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam tap_t TAP_IDLE = '{hs: 1'b1, vs: 1'b1, nb: 1'b0, pat: 12'h000};

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 12'hFFF;
      3'd1:    return 12'hFF0;
      3'd2:    return 12'h0FF;
      3'd3:    return 12'h0F0;
      3'd4:    return 12'hF0F;
      3'd5:    return 12'hF00;
      3'd6:    return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction
`else
  localparam tap_t TAP_IDLE = '{hs: 1'b1, vs: 1'b1, nb: 1'b0};
`endif

  logic [9:0]  x_q;
  logic [9:0]  y_q;
  logic        fs_q;
  logic        x_last;
  logic        y_last;
  logic [10:0] xw;
  logic [10:0] yw;
  tap_t        raw;
  tap_t        out;

  assign x_last = (x_q == X_LAST);
  assign y_last = (y_q == Y_LAST);
  assign xw     = {1'b0, x_q};
  assign yw     = {1'b0, y_q};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      x_q  <= '0;
      y_q  <= '0;
      fs_q <= 1'b0;
    end else begin
      fs_q <= vga.Ce && x_last && y_last;
      if (vga.Ce) begin
        if (x_last) begin
          x_q <= '0;
          y_q <= y_last ? '0 : y_q + 10'd1;
        end else begin
          x_q <= x_q + 10'd1;
        end
      end
    end
  end

  always_comb begin
    raw    = TAP_IDLE;
    raw.hs = !((xw >= HS_START) && (xw < HS_END));
    raw.vs = !((yw >= VS_START) && (yw < VS_END));
    raw.nb = (xw < H_VIS) && (yw < V_VIS);
`ifdef VGA_TIMING_TEST_PATTERN_EN
    raw.pat = raw.nb ? bar_colour(x_q[9:7]) : 12'h000;
`endif
  end

  // Delay line kept as one packed vector so RD_LAT=1..7 needs no per-stage indexing;
  // the newest tap enters at the bottom and the output is the top slice.
  if (RD_LAT == 0) begin : g_no_delay
    assign out = raw;
  end else begin : g_delay
    localparam int unsigned W = $bits(tap_t);
    logic [RD_LAT*W-1:0] sr;

    always_ff @(posedge Clk) begin
      if (Rst) begin
        sr <= {RD_LAT{TAP_IDLE}};
      end else if (vga.Ce) begin
        sr <= (sr << W) | (RD_LAT*W)'(raw);
      end
    end

    assign out = tap_t'(sr[RD_LAT*W-1 -: W]);
  end

  assign vga.X           = x_q;
  assign vga.Y           = y_q;
  assign vga.Hsync       = out.hs;
  assign vga.Vsync       = out.vs;
  assign vga.Nblank      = out.nb;
  assign vga.Frame_start = fs_q;
`ifdef VGA_TIMING_TEST_PATTERN_EN
  assign vga.Pattern     = out.pat;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel timing generator that sits directly upstream of the RGB colour-expansion stage.
- Produces the horizontal and vertical pixel counters, which address the 12-bit frame/pattern memory.
- Produces Hsync, Vsync and Nblank, each delayed by the memory read latency so that Nblank arrives at the RGB stage in the same cycle as the matching 12-bit Din.
- Advances only on a pixel clock-enable, so one system clock can serve several pixel rates.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- RD_LAT, 1, frame-memory read latency in pixel ticks (0..7); delay applied to sync/blank outputs

Ports:
- Clk  input  1  system clock; all logic rising-edge
- Rst  input  1  synchronous, active-high reset
- Ce  input  1  pixel tick; counters and delay line advance only when 1
- X  output  10  horizontal pixel counter (memory column address), undelayed
- Y  output  10  vertical line counter (memory row address), undelayed
- Hsync  output  1  active-low horizontal sync, delayed RD_LAT ticks
- Vsync  output  1  active-low vertical sync, delayed RD_LAT ticks
- Nblank  output  1  1 inside the visible area, delayed RD_LAT ticks; feeds the RGB stage
- Frame_start  output  1  one-Clk pulse at the start of each frame, undelayed

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Reset: X=0, Y=0, Hsync=1, Vsync=1, Nblank=0, Frame_start=0, every delay-line stage cleared to (Hs=1, Vs=1, Nb=0).
- Reset wins over Ce. Reset mid-frame restarts at (0,0) on the next Clk, with no partial sync pulse.
- Counter behaviour on Ce=1:
  - X increments; when X = H_TOTAL-1, X wraps to 0.
  - Y increments only on an X wrap; when Y = V_TOTAL-1 on an X wrap, Y wraps to 0.
- Counter behaviour on Ce=0: all state holds, including the delay line; Frame_start=0.
- Raw (undelayed) decodes, combinational from X and Y:
  - hs_raw = 0 when H_ACTIVE+H_FP <= X < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw = 0 when V_ACTIVE+V_FP <= Y < V_ACTIVE+V_FP+V_SYNC.
  - nb_raw = (X < H_ACTIVE) and (Y < V_ACTIVE).
- Delay line:
  - A shift register RD_LAT deep, advanced on Ce, carries (hs_raw, vs_raw, nb_raw).
  - Outputs are registered. Hsync, Vsync and Nblank appear at the output on the Clk edge of the RD_LAT-th Ce after the counters held the matching X, Y.
  - RD_LAT=0: outputs are the raw decodes, combinational from the counters.
- Frame_start: registered; 1 for exactly one Clk when Ce=1 and the counters are advancing from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- Width rule: X and Y are fixed at 10 bits. H_TOTAL and V_TOTAL must be <= 1024; synthesis must fail otherwise.
- The outputs carry no handshake; the downstream stage samples them whenever Ce=1.

Optional Feature:
- Macro: VGA_TIMING_TEST_PATTERN_EN.
- Defined:
  - Adds output Pattern (12 bits, 4:4:4 RGB), delayed RD_LAT ticks like Nblank.
  - Pattern is 8 vertical colour bars selected by X[9:7]: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
  - Pattern is 000 when nb_raw=0 and on reset.
  - Pattern can drive the RGB stage's Din directly, bypassing memory.
- Undefined: the port and its logic are absent.

Test Plan:
- Reset with Ce=1 held for 10 Clk, then release -> X=0, Y=0, Hsync=1, Vsync=1, Nblank=0; X reaches 10 after 10 Ce ticks.
- Defaults, Ce=1 continuously for one full line -> X wraps 799->0 and Y goes 0->1 on that tick; Hsync low for exactly 96 ticks, first low tick at X=656+RD_LAT; Nblank high for exactly 640 ticks per visible line.
- Full frame -> Vsync low for exactly 2*800 ticks during Y=490..491 (delayed by RD_LAT); Frame_start pulses once every 420000 ticks; Nblank=0 on every tick of lines 480..524.
- Ce toggling 1,0,1,0 -> counters advance once per two Clk; all outputs and the delay line frozen during Ce=0; Frame_start never lasts more than one Clk.
- RD_LAT=3 -> Nblank rises on the 3rd Ce after X=0, Y=0 and falls on the 3rd Ce after X=640; Hsync shows the same 3-tick shift.
- Assert Rst at X=700, Y=300 -> next Clk: X=0, Y=0, Nblank=0, Hsync=1 with no glitch. With VGA_TIMING_TEST_PATTERN_EN defined: Pattern=FFF at X=0, 000 at X=900 equivalent (blanked), FF0 at X=128 (after RD_LAT).
